inscache: RTL and testbench

INSCACHE -- requirements
Module: inscache

---
 rtl/inscache_pkg.sv | 21 ++
 rtl/inscache_array.sv | 73 +++++++
 rtl/inscache.sv | 179 +++++++++++++++++
 tb/tb_inscache.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inscache_pkg.sv
// Shared definitions for the instruction cache: FSM state encoding, default
// geometry and segment bounds, and a helper that derives the tag width.
package inscache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam int unsigned DEF_LINES     = 16;
  localparam int unsigned DEF_WORDS     = 4;
  localparam logic [31:0] DEF_SEG_BASE  = 32'h0000_0000;
  localparam logic [31:0] DEF_SEG_LIMIT = 32'h0001_0000;

  // Bits left above byte offset, word select and index.
  function automatic int unsigned tag_width(input int unsigned lines,
                                            input int unsigned words);
    return 32'(30 - $clog2(lines) - $clog2(words));
  endfunction

endpackage

// File: rtl/inscache_array.sv
// Tag/valid/data storage for the direct-mapped instruction cache.
// One combinational read port (lookup) and one write port (refill).
// Ports:
//   clk, rst        clock, synchronous active-high reset (valid bits only)
//   flush           clear every valid bit at the edge
//   rd_idx, rd_off  lookup line index and word select
//   rd_valid_c, rd_tag_c, rd_data_c  lookup result (unregistered)
//   wr_en           write wr_data into word wr_off of line wr_idx
//   wr_tag_en       write wr_tag and mark line wr_idx valid
//   wr_idx, wr_off, wr_data, wr_tag  write port payload
module inscache_array import inscache_pkg::*; #(
  parameter int unsigned LINES = DEF_LINES,
  parameter int unsigned WORDS = DEF_WORDS
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [$clog2(LINES)-1:0]               rd_idx,
  input  logic [$clog2(WORDS)-1:0]               rd_off,
  output logic                                   rd_valid_c,
  output logic [tag_width(LINES, WORDS)-1:0]     rd_tag_c,
  output logic [31:0]                            rd_data_c,
  input  logic                                   wr_en,
  input  logic                                   wr_tag_en,
  input  logic [$clog2(LINES)-1:0]               wr_idx,
  input  logic [$clog2(WORDS)-1:0]               wr_off,
  input  logic [31:0]                            wr_data,
  input  logic [tag_width(LINES, WORDS)-1:0]     wr_tag
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned TAG_W = tag_width(LINES, WORDS);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags  [LINES];
  logic [31:0]      words [LINES*WORDS];

  // A line being overwritten is invalid until its last word and tag land;
  // flush and reset take priority over the final-beat set.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
    end else if (wr_tag_en) begin
      valid[wr_idx] <= 1'b1;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b0;
    end
  end

  // Data storage, no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      words[{wr_idx, wr_off}] <= wr_data;
    end
  end

  // Tag storage, no reset.
  always_ff @(posedge clk) begin
    if (wr_tag_en) begin
      tags[wr_idx] <= wr_tag;
    end
  end

  assign rd_valid_c = valid[rd_idx];
  assign rd_tag_c   = tags[rd_idx];
  assign rd_data_c  = words[{rd_idx, rd_off}];

  localparam int unsigned ADDR_W_CHECK = IDX_W + OFF_W;
  if (ADDR_W_CHECK == 0) begin : g_geom_unused
  end

endmodule

// File: rtl/inscache.sv
// Direct-mapped instruction cache with one-cycle lookup, segment check and
// a single outstanding line refill from backing memory.
// Optional build macro: INSCACHE_PERF_EN adds perf_hit / perf_miss counters.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_addr, i_rd        fetch address and request strobe
//   flush               invalidate every line, abort any refill
//   i_data              fetched instruction (held when i_rd is low)
//   i_miss              fetch missed, replay later
//   i_segfault          fetch address outside segment or misaligned
//   mem_addr, mem_rd    refill word address and read request
//   mem_data, mem_vld   refill read data and its valid strobe
//   perf_hit, perf_miss saturating legal hit / miss counts (macro only)
module inscache import inscache_pkg::*; #(
  parameter int unsigned LINES     = DEF_LINES,
  parameter int unsigned WORDS     = DEF_WORDS,
  parameter logic [31:0] SEG_BASE  = DEF_SEG_BASE,
  parameter logic [31:0] SEG_LIMIT = DEF_SEG_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_rd,
  input  logic        flush,
  output logic [31:0] i_data,
  output logic        i_miss,
  output logic        i_segfault,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_data,
  input  logic        mem_vld
`ifdef INSCACHE_PERF_EN
  ,
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss
`endif
);

  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned OFF_W  = $clog2(WORDS);
  localparam int unsigned TAG_W  = tag_width(LINES, WORDS);
  localparam int unsigned LINE_W = TAG_W + IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  state_t              state;
  logic [OFF_W-1:0]    beat;
  logic [OFF_W-1:0]    beat_nxt;
  logic [LINE_W-1:0]   fill_line;

  logic [IDX_W-1:0]    lk_idx;
  logic [OFF_W-1:0]    lk_off;
  logic [TAG_W-1:0]    lk_tag;
  logic                rd_valid_c;
  logic [TAG_W-1:0]    rd_tag_c;
  logic [31:0]         rd_data_c;

  logic                below_base;
  logic                below_limit;
  logic [31:0]         lo_unused;
  logic [31:0]         hi_unused;
  logic                bad_addr;
  logic                legal_rd;
  logic                lk_hit;
  logic                lk_miss;
  logic                wr_en;
  logic                wr_tag_en;

  assign lk_off = i_addr[2 +: OFF_W];
  assign lk_idx = i_addr[2 + OFF_W +: IDX_W];
  assign lk_tag = i_addr[31 -: TAG_W];

  // Unsigned compares via 33-bit borrow so either bound may be zero.
  assign {below_base,  lo_unused} = {1'b0, i_addr} - {1'b0, SEG_BASE};
  assign {below_limit, hi_unused} = {1'b0, i_addr} - {1'b0, SEG_LIMIT};
  assign bad_addr = below_base || !below_limit || (i_addr[1:0] != 2'b00);

  assign legal_rd = i_rd && !bad_addr;
  assign lk_hit   = rd_valid_c && (rd_tag_c == lk_tag);
  assign lk_miss  = legal_rd && !lk_hit;

  // Beats are only accepted while filling; flush abandons the beat.
  assign wr_en     = (state == FILL) && mem_vld && !flush;
  assign wr_tag_en = wr_en && (beat == LAST_BEAT);
  assign beat_nxt  = beat + OFF_W'(1);

  inscache_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .rd_idx     (lk_idx),
    .rd_off     (lk_off),
    .rd_valid_c (rd_valid_c),
    .rd_tag_c   (rd_tag_c),
    .rd_data_c  (rd_data_c),
    .wr_en      (wr_en),
    .wr_tag_en  (wr_tag_en),
    .wr_idx     (fill_line[IDX_W-1:0]),
    .wr_off     (beat),
    .wr_data    (mem_data),
    .wr_tag     (fill_line[LINE_W-1 -: TAG_W])
  );

  // Lookup response and refill FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= '0;
      fill_line  <= '0;
      i_data     <= '0;
      i_miss     <= 1'b0;
      i_segfault <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
    end else begin
      i_miss     <= 1'b0;
      i_segfault <= 1'b0;
      if (i_rd) begin
        if (bad_addr) begin
          i_segfault <= 1'b1;
          i_data     <= '0;
        end else if (lk_hit) begin
          i_data     <= rd_data_c;
        end else begin
          i_miss     <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          // A coincident flush suppresses the refill.
          if (lk_miss && !flush) begin
            state     <= FILL;
            fill_line <= i_addr[31 -: LINE_W];
            beat      <= '0;
            mem_rd    <= 1'b1;
            mem_addr  <= {i_addr[31 -: LINE_W], {OFF_W{1'b0}}, 2'b00};
          end
        end
        FILL: begin
          if (flush) begin
            state  <= IDLE;
            beat   <= '0;
            mem_rd <= 1'b0;
          end else if (mem_vld) begin
            beat <= beat_nxt;
            if (beat == LAST_BEAT) begin
              state  <= IDLE;
              mem_rd <= 1'b0;
            end else begin
              mem_addr <= {fill_line, beat_nxt, 2'b00};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INSCACHE_PERF_EN
  // Saturating legal hit / miss counters; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else begin
      if (legal_rd && lk_hit && (perf_hit != '1)) begin
        perf_hit <= perf_hit + 32'd1;
      end
      if (lk_miss && (perf_miss != '1)) begin
        perf_miss <= perf_miss + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inscache.sv
// Scoreboard bench for inscache: a behavioural model pushes the expected
// post-edge outputs every cycle, a monitor pops and compares #1 after the edge.
module tb_inscache;

  localparam int unsigned LINES      = 16;
  localparam int unsigned WORDS      = 4;
  localparam int unsigned LINE_BYTES = WORDS * 4;
  localparam logic [31:0] SEG_BASE   = 32'h0000_0000;
  localparam logic [31:0] SEG_LIMIT  = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_rd = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_data;
  logic        i_miss;
  logic        i_segfault;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data = 32'h0;
  logic        mem_vld = 1'b0;
`ifdef INSCACHE_PERF_EN
  logic [31:0] perf_hit;
  logic [31:0] perf_miss;
`endif

  inscache #(
    .LINES     (LINES),
    .WORDS     (WORDS),
    .SEG_BASE  (SEG_BASE),
    .SEG_LIMIT (SEG_LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_addr     (i_addr),
    .i_rd       (i_rd),
    .flush      (flush),
    .i_data     (i_data),
    .i_miss     (i_miss),
    .i_segfault (i_segfault),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_vld    (mem_vld)
`ifdef INSCACHE_PERF_EN
    ,
    .perf_hit   (perf_hit),
    .perf_miss  (perf_miss)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
    logic        miss;
    logic        seg;
    logic        mrd;
    logic        chk_maddr;
    logic [31:0] maddr;
    logic [31:0] ph;
    logic [31:0] pm;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_to     = 0;

  logic        pulse = 1'b0;
  int unsigned resp_prob  = 0;
  int unsigned stray_prob = 0;
  logic [31:0] seg_lo = SEG_BASE;
  logic [31:0] seg_hi = SEG_LIMIT;

  // Reference model state: which memory line each cache slot holds.
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  bit          m_filling = 1'b0;
  int unsigned m_fill_base = 0;
  int unsigned m_beats = 0;
  logic [31:0] m_data = 32'h0;
  bit          m_data_known = 1'b1;
  logic [31:0] m_maddr = 32'h0;
  logic [31:0] m_ph = 32'h0;
  logic [31:0] m_pm = 32'h0;

  // Backing memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory responder: answers requests randomly, on demand, or spuriously.
  always @(negedge clk) begin
    #1;
    mem_vld  = pulse
             | (mem_rd && ($urandom_range(0, 99) < resp_prob))
             | ($urandom_range(0, 99) < stray_prob);
    mem_data = mem_word(mem_addr);
  end

  // Reference model: expected outputs after this edge.
  always @(posedge clk) begin : model
    exp_t        e;
    int unsigned ln;
    int unsigned ix;
    int unsigned tg;
    int unsigned fl;
    bit          seg;
    bit          hit;
    bit          miss;
    seg  = 1'b0;
    miss = 1'b0;
    if (rst) begin
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      m_filling    = 1'b0;
      m_beats      = 0;
      m_data       = 32'h0;
      m_data_known = 1'b1;
      m_maddr      = 32'h0;
      m_ph         = 32'h0;
      m_pm         = 32'h0;
    end else begin
      seg  = i_rd && ((i_addr < seg_lo) || (i_addr >= seg_hi) || ((i_addr % 4) != 0));
      ln   = i_addr / LINE_BYTES;
      ix   = ln % LINES;
      tg   = ln / LINES;
      hit  = i_rd && !seg && m_valid[ix] && (m_tag[ix] == tg);
      miss = i_rd && !seg && !hit;
      if (seg) begin
        m_data = 32'h0;
        m_data_known = 1'b1;
      end else if (hit) begin
        m_data = mem_word(i_addr);
        m_data_known = 1'b1;
      end else if (miss) begin
        m_data_known = 1'b0;
      end
      if (hit && m_ph != 32'hFFFF_FFFF) m_ph = m_ph + 1;
      if (miss && m_pm != 32'hFFFF_FFFF) m_pm = m_pm + 1;

      if (m_filling) begin
        if (flush) begin
          m_filling = 1'b0;
        end else if (mem_vld) begin
          fl = (m_fill_base / LINE_BYTES) % LINES;
          m_valid[fl] = 1'b0;
          m_beats = m_beats + 1;
          if (m_beats == WORDS) begin
            m_valid[fl] = 1'b1;
            m_tag[fl]   = (m_fill_base / LINE_BYTES) / LINES;
            m_filling   = 1'b0;
          end else begin
            m_maddr = m_fill_base + 4 * m_beats;
          end
        end
      end else if (miss && !flush) begin
        m_filling   = 1'b1;
        m_fill_base = i_addr - (i_addr % LINE_BYTES);
        m_beats     = 0;
        m_maddr     = m_fill_base;
      end
      if (flush) begin
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      end
    end
    e.chk_data  = m_data_known;
    e.data      = m_data;
    e.miss      = miss;
    e.seg       = seg;
    e.mrd       = m_filling;
    e.chk_maddr = m_filling || rst;
    e.maddr     = m_maddr;
    e.ph        = m_ph;
    e.pm        = m_pm;
    sb.push_back(e);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: compare DUT outputs against each expected record.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("i_miss", 32'(i_miss), 32'(e.miss));
      chk("i_segfault", 32'(i_segfault), 32'(e.seg));
      chk("mem_rd", 32'(mem_rd), 32'(e.mrd));
      if (e.chk_data) chk("i_data", i_data, e.data);
      if (e.chk_maddr) chk("mem_addr", mem_addr, e.maddr);
`ifdef INSCACHE_PERF_EN
      chk("perf_hit", perf_hit, e.ph);
      chk("perf_miss", perf_miss, e.pm);
`endif
    end
  end

  task automatic drive(input logic r, input logic [31:0] a, input logic f,
                       input logic rs, input logic p);
    @(negedge clk);
    rst    = rs;
    i_rd   = r;
    i_addr = a;
    flush  = f;
    pulse  = p;
  endtask

  task automatic idle(input logic p);
    drive(1'b0, 32'h0, 1'b0, 1'b0, p);
  endtask

  task automatic wait_fill(input int unsigned prob);
    int unsigned n;
    n = 0;
    resp_prob = prob;
    do begin
      idle(1'b0);
      n++;
    end while (m_filling && n < 400);
    if (m_filling) begin
      n_to++;
      $display("FAIL fill_timeout: refill still busy after %0d cycles, required idle", n);
    end
  endtask

  initial begin
    logic [31:0] a;
    int unsigned k;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Cold miss on 0x100, four beats, then hit on the second word.
    drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    wait_fill(50);
    drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    drive(1'b1, 32'h10C, 1'b0, 1'b0, 1'b0);

    // Segment and alignment faults.
    drive(1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h102, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_FFFC, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Hit during fill: 0x000 resident, 0x200 refill pending.
    drive(1'b1, 32'h000, 1'b0, 1'b0, 1'b0);
    wait_fill(60);
    resp_prob = 0;
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h004, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h208, 1'b0, 1'b0, 1'b0);
    wait_fill(70);
    drive(1'b1, 32'h208, 1'b0, 1'b0, 1'b0);

    // Conflict on the same index.
    drive(1'b1, 32'h000, 1'b0, 1'b0, 1'b0);
    wait_fill(70);
    drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    wait_fill(70);
    drive(1'b1, 32'h000, 1'b0, 1'b0, 1'b0);
    wait_fill(70);

    // Flush after two beats, late beat ignored, flush coincident with miss.
    resp_prob = 0;
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    drive(1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    wait_fill(70);
    drive(1'b1, 32'h20C, 1'b0, 1'b0, 1'b0);

    // Reset after two beats behaves like flush.
    resp_prob = 0;
    drive(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    drive(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
    wait_fill(70);
    drive(1'b1, 32'h604, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h608, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h600, 1'b1, 1'b0, 1'b0);
    idle(1'b0);

    // Randomised traffic with flushes, resets and stray beats.
    stray_prob = 3;
    resp_prob  = 60;
    for (int n = 0; n < 3000; n++) begin
      k = $urandom_range(0, 99);
      if (k < 5)
        a = SEG_LIMIT + ($urandom_range(0, 1023) << 2);
      else if (k < 10)
        a = ($urandom_range(0, 47) * LINE_BYTES) + $urandom_range(1, 3);
      else
        a = ($urandom_range(0, 47) * LINE_BYTES) + ($urandom_range(0, WORDS - 1) * 4);
      drive($urandom_range(0, 99) < 70, a, $urandom_range(0, 99) < 2,
            $urandom_range(0, 299) == 0, 1'b0);
    end

    stray_prob = 0;
    wait_fill(100);
    repeat (3) idle(1'b0);
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks + n_to);
    $finish;
  end

endmodule
